// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode / write-back stage: register ID decode plus the 15 x 64-bit
// program register file with combinational reads and edge-committed writes.
module decode_writeback #(
   parameter int unsigned NREG      = 15,
   parameter logic [3:0]  RSP_ID    = 4'h4,
   parameter logic [63:0] RESET_VAL = 64'h0
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [3:0]  icode_i,
   input  logic [3:0]  rA_i,
   input  logic [3:0]  rB_i,
   input  logic        cnd_i,
   input  logic [63:0] valE_i,
   input  logic [63:0] valM_i,
   input  logic        wb_en_i,
   output logic [3:0]  srcA_o,
   output logic [3:0]  srcB_o,
   output logic [3:0]  dstE_o,
   output logic [3:0]  dstM_o,
   output logic [63:0] valA_o,
   output logic [63:0] valB_o,
   input  logic [3:0]  dbg_addr_i,
   output logic [63:0] dbg_data_o
);

   localparam int unsigned IDW = 4;
   localparam int unsigned DW  = 64;

   localparam logic [IDW-1:0] RNONE   = 4'hF;
   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_CMOVXX = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   logic [DW-1:0]  regs_q [NREG];
   logic [DW-1:0]  regs_d [NREG];
   logic [IDW-1:0] src_a, src_b, dst_e, dst_m;

   // Register ID decode; unlisted and invalid icodes leave every ID at RNONE
   always_comb begin
      src_a = RNONE;
      src_b = RNONE;
      dst_e = RNONE;
      dst_m = RNONE;
      case (icode_i)
         I_CMOVXX: begin
            src_a = rA_i;
            dst_e = cnd_i ? rB_i : RNONE;
         end
         I_IRMOVQ: dst_e = rB_i;
         I_RMMOVQ: begin
            src_a = rA_i;
            src_b = rB_i;
         end
         I_MRMOVQ: begin
            src_b = rB_i;
            dst_m = rA_i;
         end
         I_OPQ: begin
            src_a = rA_i;
            src_b = rB_i;
            dst_e = rB_i;
         end
         I_CALL: begin
            src_b = RSP_ID;
            dst_e = RSP_ID;
         end
         I_RET: begin
            src_a = RSP_ID;
            src_b = RSP_ID;
            dst_e = RSP_ID;
         end
         I_PUSHQ: begin
            src_a = rA_i;
            src_b = RSP_ID;
            dst_e = RSP_ID;
         end
         I_POPQ: begin
            src_a = RSP_ID;
            src_b = RSP_ID;
            dst_e = RSP_ID;
            dst_m = rA_i;
         end
         I_HALT, I_NOP, I_JXX: ;
         default: ;
      endcase
   end

   assign srcA_o = src_a;
   assign srcB_o = src_b;
   assign dstE_o = dst_e;
   assign dstM_o = dst_m;

   // Next register state; the M port is applied last so it wins a collision
   always_comb begin
      for (int unsigned i = 0; i < NREG; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (wb_en_i) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            if (dst_e == IDW'(i)) regs_d[i] = valE_i;
         end
         for (int unsigned i = 0; i < NREG; i++) begin
            if (dst_m == IDW'(i)) regs_d[i] = valM_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs_q[i] <= RESET_VAL;
         end
      end else begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Read ports: pre-edge register contents, zero for RNONE
   always_comb begin
      valA_o     = '0;
      valB_o     = '0;
      dbg_data_o = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (src_a == IDW'(i))      valA_o     = regs_q[i];
         if (src_b == IDW'(i))      valB_o     = regs_q[i];
         if (dbg_addr_i == IDW'(i)) dbg_data_o = regs_q[i];
      end
   end

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback: expectations are queued as stimulus is
// driven and popped against DUT outputs sampled mid-cycle.
module tb_decode_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  icode, ra, rb;
   logic        cnd;
   logic [63:0] val_e, val_m;
   logic        wb_en;
   logic [3:0]  src_a, src_b, dst_e, dst_m;
   logic [63:0] val_a, val_b;
   logic [3:0]  dbg_addr;
   logic [63:0] dbg_data;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [63:0] model [15];
   string       tag_q [$];
   logic [63:0] exp_q [$];

   decode_writeback dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .icode_i    (icode),
      .rA_i       (ra),
      .rB_i       (rb),
      .cnd_i      (cnd),
      .valE_i     (val_e),
      .valM_i     (val_m),
      .wb_en_i    (wb_en),
      .srcA_o     (src_a),
      .srcB_o     (src_b),
      .dstE_o     (dst_e),
      .dstM_o     (dst_m),
      .valA_o     (val_a),
      .valB_o     (val_b),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data)
   );

   always #50 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [63:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic sb_pop(input logic [63:0] obs);
      if (exp_q.size() == 0) begin
         check_eq("sb_underflow", 64'd1, 64'd0);
      end else begin
         check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
      end
   endtask

   task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic [63:0] e, input logic [63:0] m,
                        input logic en);
      icode = ic; ra = a; rb = b; cnd = c; val_e = e; val_m = m; wb_en = en;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic chk_ids(input string name, input logic [3:0] sa, input logic [3:0] sb,
                          input logic [3:0] de, input logic [3:0] dm);
      sb_push({name, ".srcA"}, 64'(sa));
      sb_push({name, ".srcB"}, 64'(sb));
      sb_push({name, ".dstE"}, 64'(de));
      sb_push({name, ".dstM"}, 64'(dm));
      #1;
      sb_pop(64'(src_a));
      sb_pop(64'(src_b));
      sb_pop(64'(dst_e));
      sb_pop(64'(dst_m));
   endtask

   task automatic chk_vals(input string name, input logic [63:0] a, input logic [63:0] b);
      sb_push({name, ".valA"}, a);
      sb_push({name, ".valB"}, b);
      #1;
      sb_pop(val_a);
      sb_pop(val_b);
   endtask

   // Read every ID (including RNONE) over the debug port against the model
   task automatic dump(input string name);
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i);
         sb_push($sformatf("%s.R%0d", name, i), (i == 15) ? 64'h0 : model[i]);
         #1;
         sb_pop(dbg_data);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 15; i++) model[i] = 64'h0;
   endtask

   task automatic irmovq(input logic [3:0] rdst, input logic [63:0] v);
      drive(4'h3, 4'hF, rdst, 1'b0, v, 64'h0, 1'b1);
      step();
      if (rdst != 4'hF) model[rdst] = v;
   endtask

   initial begin
      model_clear();
      rst_n    = 1'b0;
      dbg_addr = 4'h0;
      drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
      repeat (2) @(negedge clk);
      dump("reset");
      rst_n = 1'b1;
      #1;

      // irmovq $9, %rdx
      drive(4'h3, 4'hF, 4'h2, 1'b0, 64'd9, 64'h0, 1'b1);
      chk_ids("irmovq", 4'hF, 4'hF, 4'h2, 4'hF);
      step();
      model[2] = 64'd9;
      dump("irmovq");

      // async reset mid-cycle with a write pending
      #2;
      drive(4'h3, 4'hF, 4'h7, 1'b0, 64'd5, 64'h0, 1'b1);
      rst_n = 1'b0;
      model_clear();
      #1;
      dump("rst_async");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      dump("rst_hold");
      step();
      model[7] = 64'd5;
      dump("rst_first");

      // OPQ reads pre-edge values, writes rB
      irmovq(4'h2, 64'd9);
      irmovq(4'h3, 64'd21);
      drive(4'h6, 4'h2, 4'h3, 1'b0, 64'd12, 64'h0, 1'b1);
      chk_ids("opq", 4'h2, 4'h3, 4'h3, 4'hF);
      chk_vals("opq", 64'd9, 64'd21);
      step();
      model[3] = 64'd12;
      dump("opq");

      // popq %rsp: M port wins the collision
      irmovq(4'h4, 64'd128);
      drive(4'hB, 4'h4, 4'hF, 1'b0, 64'd136, 64'd55, 1'b1);
      chk_ids("popq", 4'h4, 4'h4, 4'h4, 4'h4);
      chk_vals("popq", 64'd128, 64'd128);
      step();
      model[4] = 64'd55;
      dump("popq");

      // cmov gated off then on
      drive(4'h2, 4'h2, 4'h5, 1'b0, 64'd7, 64'h0, 1'b1);
      chk_ids("cmov0", 4'h2, 4'hF, 4'hF, 4'hF);
      chk_vals("cmov0", 64'd9, 64'd0);
      step();
      dump("cmov0");
      drive(4'h2, 4'h2, 4'h5, 1'b1, 64'd7, 64'h0, 1'b1);
      chk_ids("cmov1", 4'h2, 4'hF, 4'h5, 4'hF);
      step();
      model[5] = 64'd7;
      dump("cmov1");

      // write inhibit
      drive(4'h3, 4'hF, 4'h6, 1'b0, 64'd99, 64'h0, 1'b0);
      chk_ids("wbdis", 4'hF, 4'hF, 4'h6, 4'hF);
      step();
      dump("wbdis");

      // invalid icode
      drive(4'hC, 4'h2, 4'h3, 1'b1, 64'd77, 64'd88, 1'b1);
      chk_ids("inv", 4'hF, 4'hF, 4'hF, 4'hF);
      chk_vals("inv", 64'd0, 64'd0);
      step();
      dump("inv");

      // mrmovq full-width valM, top register ID, write to RNONE dropped
      drive(4'h5, 4'h8, 4'h2, 1'b0, 64'd1, 64'hDEAD_BEEF_0123_4567, 1'b1);
      chk_ids("mrmovq", 4'hF, 4'h2, 4'hF, 4'h8);
      step();
      model[8] = 64'hDEAD_BEEF_0123_4567;
      irmovq(4'hE, 64'hFFFF_FFFF_FFFF_FFFF);
      irmovq(4'hF, 64'h1234);
      drive(4'hA, 4'hE, 4'hF, 1'b0, 64'd120, 64'h0, 1'b1);
      chk_ids("pushq", 4'hE, 4'h4, 4'h4, 4'hF);
      chk_vals("pushq", 64'hFFFF_FFFF_FFFF_FFFF, 64'd55);
      step();
      model[4] = 64'd120;
      drive(4'h8, 4'hF, 4'hF, 1'b0, 64'd112, 64'h0, 1'b1);
      chk_ids("call", 4'hF, 4'h4, 4'h4, 4'hF);
      step();
      model[4] = 64'd112;
      drive(4'h9, 4'hF, 4'hF, 1'b0, 64'd120, 64'h0, 1'b1);
      chk_ids("ret", 4'h4, 4'h4, 4'h4, 4'hF);
      step();
      model[4] = 64'd120;
      drive(4'h4, 4'h3, 4'h8, 1'b0, 64'd0, 64'h0, 1'b1);
      chk_ids("rmmovq", 4'h3, 4'h8, 4'hF, 4'hF);
      chk_vals("rmmovq", 64'd12, 64'hDEAD_BEEF_0123_4567);
      step();
      dump("final");

      check_eq("sb_leftover", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
